i2s_tx: RTL and testbench

//  Downstream output stage of the moving-average filter: takes its signed mono sample, reduces
//  it to DAC width, duplicates it to L/R and serialises it as standard I2S (1-bit MSB delay).

---
 rtl/audio_pkg.sv | 16 +
 rtl/i2s_sample_reduce.sv | 48 ++++
 rtl/i2s_tx.sv | 154 +++++++++++++++
 tb/tb_i2s_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample widths used by the moving-average
// filter and the I2S output stage, plus the I2S transmitter FSM state type.
// Build option I2S_TX_ROUND_EN (consumed by i2s_sample_reduce) selects rounding.
package audio_pkg;

  localparam int unsigned AUDIO_BIT_WIDTH = 32;  // filter output sample width
  localparam int unsigned AUDIO_OUT_WIDTH = 24;  // DAC sample width
  localparam int unsigned I2S_SLOT_WIDTH  = 32;  // BCLKs per channel slot
  localparam int unsigned I2S_BCLK_DIV    = 4;   // clk cycles per BCLK period

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/i2s_sample_reduce.sv
// Width reduction of a signed sample from BIT_WIDTH down to OUT_WIDTH.
// Default: truncation (floor toward -inf).
// Macro I2S_TX_ROUND_EN: round-half-up in BIT_WIDTH+1 bits, then saturate.
module i2s_sample_reduce
  import audio_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = AUDIO_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH = AUDIO_OUT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] sample_i,
  output logic [OUT_WIDTH-1:0] sample_o
);

  localparam int unsigned SH = BIT_WIDTH - OUT_WIDTH;

  if (SH == 0) begin : g_pass
    assign sample_o = sample_i;
  end else begin : g_reduce
`ifdef I2S_TX_ROUND_EN
    localparam logic [BIT_WIDTH:0] HALF = (BIT_WIDTH+1)'(1) << (SH - 1);

    logic [BIT_WIDTH:0] sum;
    logic [OUT_WIDTH:0] hi;
    logic               unused_sum_lsb;

    // Round half up; only positive overflow is reachable, but both rails are handled.
    always_comb begin
      sum = {sample_i[BIT_WIDTH-1], sample_i} + HALF;
      hi  = sum[BIT_WIDTH -: OUT_WIDTH+1];
      if (hi[OUT_WIDTH] == hi[OUT_WIDTH-1]) begin
        sample_o = hi[OUT_WIDTH-1:0];
      end else if (!hi[OUT_WIDTH]) begin
        sample_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else begin
        sample_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end
    end

    assign unused_sum_lsb = ^sum[SH-1:0];
`else
    logic unused_lsb;

    assign sample_o   = sample_i[BIT_WIDTH-1 -: OUT_WIDTH];
    assign unused_lsb = ^sample_i[SH-1:0];
`endif
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: reduces the filter's mono sample to DAC width, duplicates it
// into both slots and serialises it MSB first with the standard 1-bit delay.
// BCLK/LRCLK are generated from clk; every output is registered.
// Build option I2S_TX_ROUND_EN selects rounding+saturation in i2s_sample_reduce.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = AUDIO_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH  = AUDIO_OUT_WIDTH,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int unsigned BCLK_DIV   = I2S_BCLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] d,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 frame_strobe,
  output logic                 busy
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned CW         = $clog2(FRAME_BITS);
  localparam int unsigned DW         = $clog2(BCLK_DIV);

  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_LIM = CW'(SLOT_WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

  i2s_state_e           state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [OUT_WIDTH-1:0] sample_q, sample_d;
  logic                 bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;

  logic [OUT_WIDTH-1:0] reduced;
  logic                 tick;
  logic [CW-1:0]        bit_inc;
  int unsigned          slot_pos;
  logic                 slot_bit;

  i2s_sample_reduce #(
    .BIT_WIDTH (BIT_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_reduce (
    .sample_i (d),
    .sample_o (reduced)
  );

  assign tick    = (div_q == DIV_LAST);
  assign bit_inc = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;

  // Serial bit for the slot position the next tick moves to (computed from bit_q+1
  // rather than bit_d so the FSM block stays free of a combinational feedback path).
  always_comb begin
    slot_pos = 32'(bit_inc) % SLOT_WIDTH;
    slot_bit = 1'b0;
    for (int unsigned i = 1; i <= OUT_WIDTH; i++) begin
      if (slot_pos == i) slot_bit = sample_q[OUT_WIDTH-i];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        if (enable) begin
          state_d  = RUN;
          sample_d = reduced;
          strobe_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        div_d  = tick ? '0 : div_q + 1'b1;
        bclk_d = (div_d >= DIV_HALF);
        if (tick) begin
          bit_d   = bit_inc;
          lrclk_d = (bit_inc >= SLOT_LIM);
          sdata_d = slot_bit;
          if (bit_q == BIT_LAST) begin
            if (enable) begin
              sample_d = reduced;
              strobe_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              div_d   = '0;
              bit_d   = '0;
              bclk_d  = 1'b0;
              lrclk_d = 1'b0;
              sdata_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sample_q <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_strobe = strobe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at default parameters (32/24/32/4). A frame-position model
// predicts every output each cycle; a small I2S receiver recovers the words
// for literal checks. Honours I2S_TX_ROUND_EN the same way as the design.
module tb_i2s_tx;

  localparam int BW    = 32;
  localparam int OW    = 24;
  localparam int SW    = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SW * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [BW-1:0] d = '0;
  logic          bclk, lrclk, sdata, frame_strobe, busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  i2s_tx #(
    .BIT_WIDTH  (BW),
    .OUT_WIDTH  (OW),
    .SLOT_WIDTH (SW),
    .BCLK_DIV   (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .d            (d),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_strobe (frame_strobe),
    .busy         (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference reduction in plain integer arithmetic.
  function automatic logic [23:0] ref_reduce(input logic [31:0] x);
    longint v, r;
    v = longint'($signed(x));
`ifdef I2S_TX_ROUND_EN
    r = (v + 128) >>> 8;
    if (r > 8388607)  r = 8388607;
    if (r < -8388608) r = -8388608;
`else
    r = v >>> 8;
`endif
    return r[23:0];
  endfunction

  // Model: running flag, clk count since last capture, captured word.
  bit          m_run = 1'b0;
  int          m_k = 0;
  logic [23:0] m_word = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run  = 1'b1;
        m_k    = 0;
        m_word = ref_reduce(d);
      end
    end else begin
      m_k = m_k + 1;
      if (m_k == FRAME) begin
        m_k = 0;
        if (enable) m_word = ref_reduce(d);
        else m_run = 1'b0;
      end
    end
  end

  function automatic logic [4:0] model_out();
    int b, p;
    logic e_bclk, e_lr, e_sd;
    if (!m_run) return 5'b0;
    b      = m_k / DIV;
    p      = b % SW;
    e_bclk = (m_k % DIV) >= DIV / 2;
    e_lr   = (b >= SW);
    e_sd   = (p >= 1 && p <= OW) ? m_word[OW-p] : 1'b0;
    return {e_bclk, e_lr, e_sd, (m_k == 0), 1'b1};
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [4:0] got, exp;
    got = {bclk, lrclk, sdata, frame_strobe, busy};
    exp = model_out();
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL outputs t=%0t {bclk,lrclk,sdata,strobe,busy} got %b required %b", $time, got, exp);
    end
  end

  // I2S receiver: sample sdata on BCLK rising, 1-bit delay after slot start.
  int          rx_pos = -1;
  logic [23:0] rx_sh = '0;
  logic [23:0] rx_word = '0;
  logic        rx_lr = 1'b0;
  int          rx_cnt = 0;
  logic        prev_bclk = 1'b0;
  int          last_strobe = 0;
  int          prev_strobe = 0;

  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      rx_pos    = -1;
      prev_bclk = 1'b0;
    end else begin
      if (frame_strobe) begin
        rx_pos      = -1;
        prev_strobe = last_strobe;
        last_strobe = cyc;
      end
      if (bclk && !prev_bclk) begin
        rx_pos = (rx_pos + 1) % (2 * SW);
        if ((rx_pos % SW) >= 1 && (rx_pos % SW) <= OW) rx_sh = {rx_sh[22:0], sdata};
        if ((rx_pos % SW) == OW) begin
          rx_word = rx_sh;
          rx_lr   = lrclk;
          rx_cnt++;
        end
      end
      prev_bclk = bclk;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input string name);
    int start, t;
    start = rx_cnt;
    t = 0;
    while (rx_cnt == start && t < 600) begin
      step();
      t++;
    end
    if (rx_cnt == start) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s timeout got no word required one within 600 clk", name);
    end
  endtask

  logic [31:0] vecs [4] = '{32'h12345680, 32'h7FFFFF80, 32'h80000000, 32'hFFFFFFFF};
`ifdef I2S_TX_ROUND_EN
  logic [23:0] exps [4] = '{24'h123457, 24'h7FFFFF, 24'h800000, 24'h000000};
`else
  logic [23:0] exps [4] = '{24'h123456, 24'h7FFFFF, 24'h800000, 24'hFFFFFF};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs, t;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {bclk, lrclk, sdata, frame_strobe, busy}, 0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_no_enable", busy, 0);

    // Pin the reference reduction with hand-computed values.
    chk("ref_12345678", ref_reduce(32'h12345678), 24'h123456);
    chk("ref_7FFFFF80", ref_reduce(32'h7FFFFF80), 24'h7FFFFF);
    chk("ref_80000000", ref_reduce(32'h80000000), 24'h800000);
`ifdef I2S_TX_ROUND_EN
    chk("ref_12345680", ref_reduce(32'h12345680), 24'h123457);
    chk("ref_FFFFFFFF", ref_reduce(32'hFFFFFFFF), 24'h000000);
`else
    chk("ref_12345680", ref_reduce(32'h12345680), 24'h123456);
    chk("ref_FFFFFFFF", ref_reduce(32'hFFFFFFFF), 24'hFFFFFF);
`endif

    // Basic transmission of one word in both slots.
    d = 32'h12345678;
    enable = 1'b1;
    step();
    chk("first_strobe", frame_strobe, 1);
    chk("first_busy", busy, 1);
    wait_rx("t1_left");
    chk("t1_left_word", rx_word, 24'h123456);
    chk("t1_left_lr", rx_lr, 0);
    wait_rx("t1_right");
    chk("t1_right_word", rx_word, 24'h123456);
    chk("t1_right_lr", rx_lr, 1);

    // Reduction corner cases; d disturbed mid-frame must not reach the wire.
    for (int i = 0; i < 4; i++) begin
      d = vecs[i];
      wait_rx("vec_left");
      chk($sformatf("vec%0d_left", i), rx_word, exps[i]);
      d = 32'hDEADBEEF;
      wait_rx("vec_right");
      chk($sformatf("vec%0d_right", i), rx_word, exps[i]);
    end
    chk("strobe_period", last_strobe - prev_strobe, FRAME);

    // Drop enable at bit_cnt 10: frame completes, then idle.
    t = 0;
    while (!frame_strobe && t < 400) begin
      step();
      t++;
    end
    chk("t5_strobe_seen", frame_strobe, 1);
    cs = cyc;
    repeat (40) step();
    enable = 1'b0;
    t = 0;
    while (busy && t < 400) begin
      step();
      t++;
    end
    chk("t5_busy_fall_delay", cyc - cs, FRAME);
    chk("t5_idle_outputs", {bclk, lrclk, sdata, frame_strobe, busy}, 0);
    repeat (10) step();
    chk("t5_stays_idle", busy, 0);
    d = 32'h80000000;
    enable = 1'b1;
    step();
    chk("t5_restart_strobe", frame_strobe, 1);
    wait_rx("t5_left");
    chk("t5_restart_word", rx_word, 24'h800000);
    chk("t5_restart_lr", rx_lr, 0);

    // Asynchronous reset mid-frame.
    repeat (60) step();
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", {bclk, lrclk, sdata, frame_strobe, busy}, 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("t6_idle_after_reset", busy, 0);
    d = 32'h12345678;
    enable = 1'b1;
    step();
    chk("t6_restart_strobe", frame_strobe, 1);
    wait_rx("t6_left");
    chk("t6_restart_word", rx_word, 24'h123456);

    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
